// File: rtl/input_conditioner_bank.sv
// Multi-channel input conditioner: synchronise, debounce and edge-detect asynchronous status lines.
// Optional sticky event flags are compiled in with CONDITIONER_STICKY_EN.
module input_conditioner_bank #(
   parameter int unsigned CHANNELS    = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE_W  = 8,
   parameter logic        RESET_LEVEL = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [CHANNELS-1:0]     input_async,
   input  logic [2*CHANNELS-1:0]   edge_mode,
   input  logic [DEBOUNCE_W-1:0]   debounce_limit,
   input  logic [CHANNELS-1:0]     event_clear,
   output logic [CHANNELS-1:0]     level_out,
   output logic [CHANNELS-1:0]     output_edge,
   output logic [CHANNELS-1:0]     event_pending,
   output logic                    any_event
);

   logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
   logic [CHANNELS-1:0]                  sync_s;
   logic [DEBOUNCE_W-1:0]                cnt_q [CHANNELS];
   logic [DEBOUNCE_W-1:0]                cnt_d [CHANNELS];
   logic [CHANNELS-1:0]                  level_q, level_d;
   logic [CHANNELS-1:0]                  edge_q, edge_d;

   // Synchroniser chain; stage 0 captures the raw input.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{{CHANNELS{RESET_LEVEL}}}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], input_async};
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Debounce: a change is accepted once it has outlasted debounce_limit extra cycles.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      edge_d  = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (sync_s[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] >= debounce_limit) begin
            cnt_d[i]   = '0;
            level_d[i] = sync_s[i];
            edge_d[i]  = sync_s[i] ? edge_mode[2*i] : edge_mode[2*i+1];
         end else begin
            cnt_d[i] = DEBOUNCE_W'(cnt_q[i] + 1'b1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_q <= {CHANNELS{RESET_LEVEL}};
         edge_q  <= '0;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         level_q <= level_d;
         edge_q  <= edge_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_out   = level_q;
   assign output_edge = edge_q;

`ifdef CONDITIONER_STICKY_EN
   logic [CHANNELS-1:0] pend_q, pend_d;

   // A new edge takes priority over a clear in the same cycle.
   always_comb begin
      pend_d = (pend_q & ~event_clear) | edge_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign event_pending = pend_q;
   assign any_event     = |pend_q;
`else
   logic clear_unused;

   assign clear_unused  = ^event_clear;
   assign event_pending = '0;
   assign any_event     = 1'b0;
`endif

endmodule
